// File: rtl/keypad_pkg.sv
// Shared key codes, entry limits and the keypad (col,row) -> key code map.
package keypad_pkg;

    typedef logic [4:0] key_t;  // bit 4 set means no key

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;
    localparam key_t       KEY_NONE = 5'h10;

    localparam int MAX_DIGITS = 3;
    localparam int MAX_VALUE  = 255;

    function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
        case ({col, row})
            4'h0:    return KEY_1;
            4'h1:    return KEY_4;
            4'h2:    return KEY_7;
            4'h3:    return KEY_STAR;
            4'h4:    return KEY_2;
            4'h5:    return KEY_5;
            4'h6:    return KEY_8;
            4'h7:    return KEY_0;
            4'h8:    return KEY_3;
            4'h9:    return KEY_6;
            4'hA:    return KEY_9;
            4'hB:    return KEY_HASH;
            4'hC:    return KEY_A;
            4'hD:    return KEY_B;
            4'hE:    return KEY_C;
            default: return KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with ghost rejection and scan-level debounce; emits one
// press_event per stable NONE->key transition.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       press_event
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [DW-1:0] div_reg;
    logic [1:0]    col_reg;
    logic [1:0]    scan_hits_reg;
    logic [3:0]    scan_code_reg;
    key_t          last_reg;
    key_t          stable_reg;
    logic [CW-1:0] match_reg;
    logic [3:0]    key_code_reg;
    logic          press_event_reg;

    logic          slot_end;
    logic [3:0]    active;
    logic [2:0]    col_ones;
    logic [1:0]    col_row;
    logic [2:0]    hits_sum;
    logic [1:0]    hits_next;
    logic [3:0]    code_next;
    key_t          scan_result;
    logic [CW-1:0] match_next;

    assign slot_end = (div_reg == DW'(SCAN_DIV - 1));
    assign active   = ~key_row;
    assign key_col  = ~(4'b0001 << col_reg);

    always_comb begin
        col_ones = 3'(active[0]) + 3'(active[1]) + 3'(active[2]) + 3'(active[3]);
        col_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (active[r]) col_row = 2'(r);
        end
        // Hit count saturates at 2: anything beyond one contact is ghosting.
        hits_sum    = {1'b0, scan_hits_reg} + ((col_ones > 3'd1) ? 3'd2 : col_ones);
        hits_next   = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
        code_next   = (col_ones == 3'd1) ? key_map(col_reg, col_row) : scan_code_reg;
        scan_result = (hits_next == 2'd1) ? {1'b0, code_next} : KEY_NONE;
        if (scan_result != last_reg)
            match_next = CW'(1);
        else if (match_reg == CW'(DEBOUNCE_SCANS))
            match_next = match_reg;
        else
            match_next = match_reg + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg         <= '0;
            col_reg         <= 2'd0;
            scan_hits_reg   <= 2'd0;
            scan_code_reg   <= 4'd0;
            last_reg        <= KEY_NONE;
            stable_reg      <= KEY_NONE;
            match_reg       <= '0;
            key_code_reg    <= 4'd0;
            press_event_reg <= 1'b0;
        end else begin
            press_event_reg <= 1'b0;
            div_reg         <= slot_end ? '0 : div_reg + DW'(1);
            if (slot_end) begin
                col_reg <= col_reg + 2'd1;
                if (col_reg == 2'd3) begin
                    scan_hits_reg <= 2'd0;
                    scan_code_reg <= 4'd0;
                    last_reg      <= scan_result;
                    match_reg     <= match_next;
                    if (match_next >= CW'(DEBOUNCE_SCANS)) begin
                        stable_reg <= scan_result;
                        if (stable_reg == KEY_NONE && scan_result != KEY_NONE) begin
                            press_event_reg <= 1'b1;
                            key_code_reg    <= scan_result[3:0];
                        end
                    end
                end else begin
                    scan_hits_reg <= hits_next;
                    scan_code_reg <= code_next;
                end
            end
        end
    end

    assign key_code    = key_code_reg;
    assign press_event = press_event_reg;

endmodule

// File: rtl/keypad_entry_module.sv
// Keypad entry: accumulates up to three decimal digits and converts the
// entry to an 8-bit value on '#', with a live saturated echo.
module keypad_entry_module
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       entry_err,
    output logic [7:0] echo,
    output logic [1:0] digit_count
);

    logic [3:0] key_code;
    logic       press_event;

    logic [9:0] acc_reg;
    logic [1:0] count_reg;
    logic [7:0] value_reg;
    logic       value_valid_reg;
    logic       entry_err_reg;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_scanner (
        .clk        (clk),
        .reset      (reset),
        .key_row    (key_row),
        .key_col    (key_col),
        .key_code   (key_code),
        .press_event(press_event)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg         <= 10'd0;
            count_reg       <= 2'd0;
            value_reg       <= 8'd0;
            value_valid_reg <= 1'b0;
            entry_err_reg   <= 1'b0;
        end else begin
            value_valid_reg <= 1'b0;
            entry_err_reg   <= 1'b0;
            if (press_event) begin
                if (key_code <= KEY_9) begin
                    // count < 3 bounds acc to 99 here, so the result fits 10 bits
                    if (count_reg < 2'(MAX_DIGITS)) begin
                        acc_reg   <= acc_reg * 10'd10 + {6'd0, key_code};
                        count_reg <= count_reg + 2'd1;
                    end else begin
                        entry_err_reg <= 1'b1;
                    end
                end else if (key_code == KEY_STAR) begin
                    acc_reg   <= 10'd0;
                    count_reg <= 2'd0;
                end else if (key_code == KEY_HASH && count_reg != 2'd0) begin
                    if (acc_reg <= 10'(MAX_VALUE)) begin
                        value_reg       <= acc_reg[7:0];
                        value_valid_reg <= 1'b1;
                    end else begin
                        entry_err_reg <= 1'b1;
                    end
                    acc_reg   <= 10'd0;
                    count_reg <= 2'd0;
                end
            end
        end
    end

    assign echo        = (acc_reg > 10'(MAX_VALUE)) ? 8'hFF : acc_reg[7:0];
    assign value       = value_reg;
    assign value_valid = value_valid_reg;
    assign entry_err   = entry_err_reg;
    assign digit_count = count_reg;

endmodule

// File: tb/tb_keypad_entry_module.sv
// Directed bench for keypad_entry_module with a matrix keypad model.
module tb_keypad_entry_module;

    localparam int SD   = 2;
    localparam int DB   = 2;
    localparam int SCAN = 4 * SD;

    logic       clk;
    logic       reset;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [7:0] value;
    logic       value_valid;
    logic       entry_err;
    logic [7:0] echo;
    logic [1:0] digit_count;

    logic [15:0] pressed;  // bit col*4+row
    int total = 0;
    int bad   = 0;
    int vv_cnt = 0;
    int err_cnt = 0;
    logic prev_vv = 1'b0;
    logic prev_err = 1'b0;

    keypad_entry_module #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_row    (key_row),
        .key_col    (key_col),
        .value      (value),
        .value_valid(value_valid),
        .entry_err  (entry_err),
        .echo       (echo),
        .digit_count(digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        key_row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    function automatic int key_pos(input int code);
        case (code)
            1: return 0;   4: return 1;   7: return 2;   14: return 3;
            2: return 4;   5: return 5;   8: return 6;   0: return 7;
            3: return 8;   6: return 9;   9: return 10;  15: return 11;
            10: return 12; 11: return 13; 12: return 14; default: return 15;
        endcase
    endfunction

    task automatic press(input int code, input int scans);
        pressed = 16'd1 << key_pos(code);
        repeat (scans * SCAN) @(negedge clk);
        pressed = 16'd0;
        repeat (3 * SCAN) @(negedge clk);
    endtask

    task automatic align_scan();
        logic [3:0] prev;
        bit found;
        found = 0;
        prev = key_col;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (key_col == 4'b1110 && prev == 4'b0111) found = 1;
            prev = key_col;
        end
        if (!found) chk("align_timeout", 32'd1, 32'd0);
    endtask

    // Strobe monitor: exclusivity and one-cycle width.
    always @(negedge clk) begin
        if (!reset) begin
            if (value_valid || entry_err)
                chk("strobe_excl", 32'(value_valid & entry_err), 32'd0);
            if (value_valid) begin
                chk("vv_width", 32'(prev_vv), 32'd0);
                vv_cnt++;
            end
            if (entry_err) begin
                chk("err_width", 32'(prev_err), 32'd0);
                err_cnt++;
            end
        end
        prev_vv  = value_valid;
        prev_err = entry_err;
    end

    initial begin
        logic [3:0] col_seq [4];
        col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        pressed = 16'd0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_key_col", 32'(key_col), 32'hE);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_vv", 32'(value_valid), 32'd0);
        chk("rst_err", 32'(entry_err), 32'd0);
        chk("rst_echo", 32'(echo), 32'd0);
        chk("rst_count", 32'(digit_count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            repeat (SD) @(negedge clk);
            chk("col_step", 32'(key_col), 32'(col_seq[k]));
        end

        press(1, 3);  chk("e1_echo", 32'(echo), 32'd1);   chk("e1_cnt", 32'(digit_count), 32'd1);
        press(2, 3);  chk("e12_echo", 32'(echo), 32'd12); chk("e12_cnt", 32'(digit_count), 32'd2);
        press(3, 3);  chk("e123_echo", 32'(echo), 32'd123); chk("e123_cnt", 32'(digit_count), 32'd3);
        press(15, 3);
        chk("h123_value", 32'(value), 32'd123);
        chk("h123_vv_cnt", 32'(vv_cnt), 32'd1);
        chk("h123_err_cnt", 32'(err_cnt), 32'd0);
        chk("h123_echo", 32'(echo), 32'd0);
        chk("h123_cnt", 32'(digit_count), 32'd0);

        press(2, 3); press(5, 3); press(6, 3);
        chk("e256_echo", 32'(echo), 32'd255);
        chk("e256_cnt", 32'(digit_count), 32'd3);
        press(15, 3);
        chk("h256_err_cnt", 32'(err_cnt), 32'd1);
        chk("h256_vv_cnt", 32'(vv_cnt), 32'd1);
        chk("h256_value", 32'(value), 32'd123);
        chk("h256_cnt", 32'(digit_count), 32'd0);
        chk("h256_echo", 32'(echo), 32'd0);

        press(9, 3); press(9, 3); press(9, 3);
        chk("e999_echo", 32'(echo), 32'd255);
        press(4, 3);
        chk("d4_err_cnt", 32'(err_cnt), 32'd2);
        chk("d4_echo", 32'(echo), 32'd255);
        chk("d4_cnt", 32'(digit_count), 32'd3);
        press(14, 3);
        chk("star_echo", 32'(echo), 32'd0);
        chk("star_cnt", 32'(digit_count), 32'd0);

        press(5, 20);
        chk("hold_cnt", 32'(digit_count), 32'd1);
        chk("hold_echo", 32'(echo), 32'd5);
        press(14, 3);

        // Bounce: 5, NONE, 5 over three aligned scans, then a fourth 5.
        align_scan();
        pressed = 16'd1 << key_pos(5);
        repeat (SCAN) @(negedge clk);
        pressed = 16'd0;
        repeat (SCAN) @(negedge clk);
        pressed = 16'd1 << key_pos(5);
        repeat (SCAN + 3) @(negedge clk);
        chk("bounce_cnt", 32'(digit_count), 32'd0);
        repeat (SCAN) @(negedge clk);
        chk("bounce_late_cnt", 32'(digit_count), 32'd1);
        chk("bounce_late_echo", 32'(echo), 32'd5);
        pressed = 16'd0;
        repeat (3 * SCAN) @(negedge clk);
        press(14, 3);

        pressed = (16'd1 << key_pos(1)) | (16'd1 << key_pos(4));
        repeat (3 * SCAN) @(negedge clk);
        pressed = 16'd0;
        repeat (3 * SCAN) @(negedge clk);
        chk("ghost_cnt", 32'(digit_count), 32'd0);
        chk("ghost_echo", 32'(echo), 32'd0);

        press(15, 3);
        chk("empty_hash_vv", 32'(vv_cnt), 32'd1);
        chk("empty_hash_err", 32'(err_cnt), 32'd2);

        press(4, 3); press(2, 3);
        chk("e42_echo", 32'(echo), 32'd42);
        chk("e42_cnt", 32'(digit_count), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_echo", 32'(echo), 32'd0);
        chk("mid_rst_cnt", 32'(digit_count), 32'd0);
        chk("mid_rst_value", 32'(value), 32'd0);
        chk("mid_rst_col", 32'(key_col), 32'hE);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry_module.md
Name: keypad_entry_module

Overview:
Input-side counterpart of the 7-segment display path. Scans a 4x4 matrix keypad and debounces it. Collects up to three decimal digits and converts the BCD entry to an 8-bit binary value, with a one-cycle valid strobe. Sits at the board I/O next to the display path. The echo output can feed the display input directly, so the user sees the number being typed.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven (>=2).
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a key state (>=1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_row  in  4  keypad rows, active-low (pull-ups); bit i = row i
key_col  out  4  keypad column drive, active-low one-hot
value  out  8  last accepted binary value
value_valid  out  1  one-cycle strobe: value updated
entry_err  out  1  one-cycle strobe: rejected digit or out-of-range enter
echo  out  8  live entry (binary), saturated at 255
digit_count  out  2  digits currently entered (0..3)

Behaviour:
- Reset values: key_col=4'b1110, value=0, value_valid=0, entry_err=0, echo=0, digit_count=0. Scanner, debounce and accumulator state are cleared; no event is pending.
- Scan: column index c runs 0,1,2,3,0,...
  - Each column slot lasts SCAN_DIV cycles.
  - key_col = ~(1<<c).
  - key_row is sampled on the last cycle of each slot.
  - A full scan is four slots.
- Key map (col,row):
  - col0 rows0-3 = 1,4,7,*
  - col1 = 2,5,8,0
  - col2 = 3,6,9,#
  - col3 = A,B,C,D
- Scan result:
  - Exactly one active contact gives that key code.
  - Zero contacts, or two or more (ghosting), gives NONE.
- Debounce:
  - The scan result must equal the previous one for DEBOUNCE_SCANS consecutive scans before it becomes the stable key.
  - A press event is a stable transition NONE->K, one cycle wide, on the cycle the stable key updates.
  - Holding a key produces no repeats; release (stable NONE) is required before the next event.
  - A stable transition K1->K2 without NONE between produces no event.
- Entry FSM, acting on press events only:
  - Digit d, count<3: acc <= acc*10+d (10-bit, max 999); count++.
  - Digit d, count==3: ignored; entry_err pulses.
  - '*': acc<=0, count<=0.
  - '#', count==0: ignored, no strobe.
  - '#', acc<=255: value<=acc[7:0]; value_valid pulses; acc<=0; count<=0.
  - '#', acc>255: entry_err pulses; acc<=0; count<=0; value unchanged.
  - A, B, C, D: ignored.
- Timing:
  - value, value_valid, entry_err and echo update on the cycle after the press event.
  - Strobes are exactly one cycle.
  - value_valid and entry_err are never asserted together.
- echo = (acc>255) ? 255 : acc[7:0], updated with acc.
- Leading zeros count as digits ("0","0","7" gives count 3, value 7).
- Reset asserted mid-scan or mid-entry aborts everything and returns to reset values on the next edge.

Decomposition:
- Package keypad_pkg:
  - 4-bit key code constants: KEY_0..KEY_9 = 0..9, KEY_A..KEY_D = 10..13, KEY_STAR = 14, KEY_HASH = 15.
  - Separate KEY_NONE flag or 5-bit encoding.
  - The (col,row)->code mapping function.
  - MAX_DIGITS = 3, MAX_VALUE = 255.
- One sub-module, keypad_scanner:
  - Column counter, row sampling, ghost rejection, debounce.
  - Outputs key_code plus a press_event strobe.
  - The top holds the accumulator and the entry logic.

Test Plan:
All scenarios use SCAN_DIV=2, DEBOUNCE_SCANS=2, with a bench keypad model that pulls a row low while its column is driven.
- Reset -> key_col=1110, all outputs 0; key_col then steps 1110->1101->1011->0111 every 2 cycles.
- Press 1,2,3, then # (each held 3 scans, released 3 scans) -> echo 1, 12, 123; value=123 with one value_valid pulse; digit_count 0.
- Press 2,5,6, then # -> echo 255 after the third digit; entry_err pulses on #; value keeps its previous value; digit_count 0.
- Press 9,9,9, then 4 -> entry_err pulses on the 4th digit; echo stays 255, digit_count 3; * then clears echo to 0, count to 0.
- Key 5 held 20 scans -> exactly one event. A 1-scan bounce (press, release, press) -> no event until 2 stable scans. Keys 1 and 4 together -> no event.
- # with no digits -> no strobe. Reset asserted after entering 4,2 -> echo=0, digit_count=0 next cycle; value retained as 0.
